cnn_frame_ctrl: RTL and testbench

Frame-level sequencer for the conv/pooling + DNN inference pipeline. Accepts a host pixel stream and forwards exactly one image (ImageWidth*ImageWidth pixels) into the pipeline under its ready signal. It then waits for the DNN to finish, holds the classification result for the host, and flushes the pipeline with a soft reset so the next frame starts clean. It sits between the host interface and the pipeline top level.

---
 rtl/cnn_frame_ctrl_pkg.sv | 19 +
 rtl/cnn_frame_ctrl_if.sv | 35 +++
 rtl/cnn_frame_ctrl_perf_counter.sv | 43 ++++
 rtl/cnn_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_cnn_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_frame_ctrl_pkg.sv
// Shared types and helpers for the CNN frame sequencer: FSM state encoding,
// frame size helper and the performance counter width.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    RESULT,
    FLUSH
  } frame_state_t;

  localparam int FRAME_CYCLES_W = 32;

  function automatic int frame_pixels(input int image_width);
    return image_width * image_width;
  endfunction

endpackage

// File: rtl/cnn_frame_ctrl_if.sv
// Host pixel stream, pipeline pixel/result channel and host result channel.
// master = host/pipeline side, slave = cnn_frame_ctrl.
interface cnn_frame_ctrl_if #(
  parameter int BitSize = 32,
  parameter int NumOut  = 2
);
  logic                      s_valid;
  logic [BitSize-1:0]        s_data;
  logic                      s_ready;
  logic                      pipe_valid;
  logic [BitSize-1:0]        pipe_data;
  logic                      pipe_ready;
  logic                      pipe_soft_rst;
  logic                      pipe_out_valid;
  logic [NumOut*BitSize-1:0] pipe_out_data;
  logic                      pipe_out_done;
  logic                      r_valid;
  logic [NumOut*BitSize-1:0] r_data;
  logic                      r_err;
  logic                      r_ready;

  modport master (
    output s_valid, s_data, pipe_ready, pipe_out_valid, pipe_out_data,
           pipe_out_done, r_ready,
    input  s_ready, pipe_valid, pipe_data, pipe_soft_rst, r_valid, r_data,
           r_err
  );

  modport slave (
    input  s_valid, s_data, pipe_ready, pipe_out_valid, pipe_out_data,
           pipe_out_done, r_ready,
    output s_ready, pipe_valid, pipe_data, pipe_soft_rst, r_valid, r_data,
           r_err
  );
endinterface

// File: rtl/cnn_frame_ctrl_perf_counter.sv
// Saturating frame-cycle counter with clear/enable/latch; only instantiated
// when CNN_FRAME_PERF_EN is defined.
module cnn_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic         i_latch,
  output logic [W-1:0] o_value
);
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_value;
  logic [W-1:0] w_cnt_next;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  // The clearing cycle itself counts, so the latched value spans the first
  // accepted pixel through the done cycle inclusive.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear)
      w_cnt_next = W'(1);
    else if (i_en)
      w_cnt_next = sat_inc(r_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_value <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (i_latch)
        r_value <= w_cnt_next;
    end
  end

  assign o_value = r_value;
endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer: forwards one image to the pipeline, captures the DNN result
// for the host, then flushes the pipeline. Optional CNN_FRAME_PERF_EN adds a cycle counter.
module cnn_frame_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int BitSize      = 32,
  parameter int ImageWidth   = 8,
  parameter int NumOut       = 2,
  parameter int FlushCycles  = 2,
  parameter int FrameCntBits = 8
) (
  input  logic                      clk,
  input  logic                      res_n,
  cnn_frame_ctrl_if.slave           bus,
  output logic                      busy,
  output logic [FrameCntBits-1:0]   frame_cnt,
  output logic [FRAME_CYCLES_W-1:0] frame_cycles
);
  localparam int Total  = frame_pixels(ImageWidth);
  localparam int PixW   = (Total > 1) ? $clog2(Total) : 1;
  localparam int FlushW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;

  frame_state_t              r_state;
  frame_state_t              w_next_state;
  logic [PixW-1:0]           r_pix_cnt;
  logic [FlushW-1:0]         r_flush_cnt;
  logic [FrameCntBits-1:0]   r_frame_cnt;
  logic [NumOut*BitSize-1:0] r_result;
  logic                      r_error;
  logic                      r_seen;
  logic                      w_s_ready;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_capture;
  logic                      w_in_frame;

  assign w_s_ready  = (r_state == IDLE || r_state == STREAM) && bus.pipe_ready && !res_n;
  assign w_accept   = bus.s_valid && w_s_ready;
  assign w_last     = (r_pix_cnt == PixW'(Total - 1));
  assign w_in_frame = (r_state == STREAM) || (r_state == DRAIN);
  assign w_capture  = w_in_frame && bus.pipe_out_valid;

  always_ff @(posedge clk) begin
    if (res_n)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  // Early done in STREAM wins over a coincident last-pixel accept.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = w_last ? DRAIN : STREAM;
      STREAM: begin
        if (bus.pipe_out_done)
          w_next_state = RESULT;
        else if (w_accept && w_last)
          w_next_state = DRAIN;
      end
      DRAIN:   if (bus.pipe_out_done) w_next_state = RESULT;
      RESULT:  if (bus.r_ready) w_next_state = FLUSH;
      FLUSH:   if (r_flush_cnt == '0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      r_pix_cnt   <= '0;
      r_flush_cnt <= '0;
      r_frame_cnt <= '0;
      r_result    <= '0;
      r_error     <= 1'b0;
      r_seen      <= 1'b0;
    end else begin
      if (w_next_state != STREAM)
        r_pix_cnt <= '0;
      else if (w_accept)
        r_pix_cnt <= r_pix_cnt + PixW'(1);

      if (w_capture)
        r_result <= bus.pipe_out_data;

      if (r_state == IDLE && w_accept) begin
        r_error <= 1'b0;
        r_seen  <= 1'b0;
      end else begin
        if (w_capture)
          r_seen <= 1'b1;
        if (r_state == STREAM && bus.pipe_out_done)
          r_error <= 1'b1;
        else if (r_state == DRAIN && bus.pipe_out_done)
          r_error <= !(r_seen || bus.pipe_out_valid);
      end

      if (r_state == RESULT && bus.r_ready) begin
        r_flush_cnt <= FlushW'(FlushCycles - 1);
        r_frame_cnt <= r_frame_cnt + FrameCntBits'(1);
      end else if (r_state == FLUSH && r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - FlushW'(1);
      end
    end
  end

  assign bus.s_ready       = w_s_ready;
  assign bus.pipe_valid    = w_accept;
  assign bus.pipe_data     = bus.s_data;
  assign bus.pipe_soft_rst = res_n || (r_state == FLUSH);
  assign bus.r_valid       = (r_state == RESULT);
  assign bus.r_data        = r_result;
  assign bus.r_err         = r_error;
  assign busy              = (r_state != IDLE);
  assign frame_cnt         = r_frame_cnt;

`ifdef CNN_FRAME_PERF_EN
  cnn_perf_counter #(
    .W(FRAME_CYCLES_W)
  ) u_perf (
    .clk     (clk),
    .rst     (res_n),
    .i_clear (r_state == IDLE && w_accept),
    .i_en    (w_in_frame),
    .i_latch (w_next_state == RESULT && r_state != RESULT),
    .o_value (frame_cycles)
  );
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Directed bench for cnn_frame_ctrl: nominal frame, backpressure, result
// capture, error paths, perf counter and mid-frame reset.
module tb_cnn_frame_ctrl;
  import cnn_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        res_n;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic [31:0] frame_cycles;

  cnn_frame_ctrl_if #(.BitSize(32), .NumOut(2)) bus();

  cnn_frame_ctrl #(
    .BitSize(32), .ImageWidth(8), .NumOut(2), .FlushCycles(2), .FrameCntBits(8)
  ) dut (
    .clk          (clk),
    .res_n        (res_n),
    .bus          (bus),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .frame_cycles (frame_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fwd_cnt = 0;
  int fwd_start = 0;
  int data_bad = 0;
  int ready_viol = 0;
  int srst_cnt = 0;

  // Pipeline-side monitor: every forwarded pixel must be the next in sequence.
  always @(posedge clk) begin
    if (bus.pipe_soft_rst) srst_cnt = srst_cnt + 1;
    if (bus.pipe_valid) begin
      if (bus.pipe_data !== 32'h1000 + 32'(fwd_cnt - fwd_start)) data_bad = data_bad + 1;
      if (!bus.pipe_ready) ready_viol = ready_viol + 1;
      fwd_cnt = fwd_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixels(input int n, input bit bp, output int sent, output int sready_bad);
    int cyc;
    cyc = 0;
    sent = 0;
    sready_bad = 0;
    while (sent < n && cyc < 2000) begin
      if (bp) bus.pipe_ready = ((cyc / 3) % 2) == 0;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h1000 + 32'(sent);
      #1;
      if (bus.s_ready !== bus.pipe_ready) sready_bad++;
      if (bus.s_ready === 1'b1) sent++;
      tick();
      cyc++;
    end
    bus.s_valid    = 1'b0;
    bus.pipe_ready = 1'b1;
  endtask

  task automatic finish_frame(output bit ok);
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    res_n = 1'b1;
    repeat (3) tick();
    checks++; if (bus.pipe_soft_rst !== 1'b1) begin errors++; $display("FAIL rst_soft_rst: got %0b expected 1", bus.pipe_soft_rst); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0b expected 0", bus.s_ready); end
    checks++; if (busy !== 1'b0 || bus.r_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_rvalid: got %0b/%0b expected 0/0", busy, bus.r_valid); end
    checks++; if (bus.r_data !== 64'h0 || bus.r_err !== 1'b0) begin errors++; $display("FAIL rst_result: got %0h/%0b expected 0/0", bus.r_data, bus.r_err); end
    checks++; if (frame_cnt !== 8'd0 || frame_cycles !== 32'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", frame_cnt, frame_cycles); end
    res_n = 1'b0;
    tick();
    checks++; if (bus.pipe_soft_rst !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_release: got soft_rst %0b s_ready %0b expected 0/1", bus.pipe_soft_rst, bus.s_ready); end
  endtask

  task automatic test_nominal();
    int sent, bad, s0;
    bit ok;
    fwd_start = fwd_cnt;
    s0 = srst_cnt;
    send_pixels(64, 1'b0, sent, bad);
    repeat (9) tick();
    bus.pipe_out_valid = 1'b1;
    bus.pipe_out_data  = {32'hA, 32'hB};
    tick();
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_done  = 1'b1;
    tick();
    bus.pipe_out_done  = 1'b0;
    checks++; if (fwd_cnt - fwd_start !== 64) begin errors++; $display("FAIL nom_forwarded: got %0d expected 64", fwd_cnt - fwd_start); end
    checks++; if (bus.r_valid !== 1'b1 || bus.r_err !== 1'b0) begin errors++; $display("FAIL nom_rvalid_err: got %0b/%0b expected 1/0", bus.r_valid, bus.r_err); end
    checks++; if (bus.r_data !== {32'hA, 32'hB}) begin errors++; $display("FAIL nom_rdata: got %0h expected a0000000b", bus.r_data); end
    finish_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nom_idle: got busy %0b expected 0", busy); end
    checks++; if (srst_cnt - s0 !== 2) begin errors++; $display("FAIL nom_flush_len: got %0d expected 2", srst_cnt - s0); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL nom_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_backpressure();
    int sent, bad;
    bit ok;
    fwd_start = fwd_cnt;
    send_pixels(64, 1'b1, sent, bad);
    bus.pipe_out_valid = 1'b1;
    bus.pipe_out_done  = 1'b1;
    bus.pipe_out_data  = {32'hC, 32'hD};
    tick();
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_done  = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_s_ready_track: got %0d mismatching cycles expected 0", bad); end
    checks++; if (fwd_cnt - fwd_start !== 64 || sent !== 64) begin errors++; $display("FAIL bp_forwarded: got %0d/%0d expected 64", fwd_cnt - fwd_start, sent); end
    checks++; if (ready_viol !== 0 || data_bad !== 0) begin errors++; $display("FAIL bp_integrity: got viol %0d bad %0d expected 0/0", ready_viol, data_bad); end
    checks++; if (bus.r_data !== {32'hC, 32'hD} || bus.r_err !== 1'b0) begin errors++; $display("FAIL bp_result: got %0h/%0b expected c0000000d/0", bus.r_data, bus.r_err); end
    finish_frame(ok);
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL bp_frame_cnt: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_simultaneous();
    int sent, bad;
    bit ok;
    fwd_start = fwd_cnt;
    send_pixels(64, 1'b0, sent, bad);
    tick();
    bus.pipe_out_valid = 1'b1;
    bus.pipe_out_data  = {32'h1, 32'h2};
    tick();
    bus.pipe_out_valid = 1'b0;
    tick();
    bus.pipe_out_valid = 1'b1;
    bus.pipe_out_done  = 1'b1;
    bus.pipe_out_data  = {32'h3, 32'h4};
    tick();
    bus.pipe_out_done  = 1'b0;
    bus.pipe_out_data  = {32'h9, 32'h9};
    checks++; if (bus.r_data !== {32'h3, 32'h4} || bus.r_err !== 1'b0) begin errors++; $display("FAIL sim_result: got %0h/%0b expected 300000004/0", bus.r_data, bus.r_err); end
    repeat (2) tick();
    bus.pipe_out_valid = 1'b0;
    checks++; if (bus.r_valid !== 1'b1 || bus.r_data !== {32'h3, 32'h4}) begin errors++; $display("FAIL sim_hold: got %0b/%0h expected 1/300000004", bus.r_valid, bus.r_data); end
    finish_frame(ok);
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL sim_frame_cnt: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_early_done();
    int sent, bad, leaked;
    bit ok;
    fwd_start = fwd_cnt;
    leaked = 0;
    send_pixels(20, 1'b0, sent, bad);
    bus.pipe_out_done = 1'b1;
    tick();
    bus.pipe_out_done = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.s_ready !== 1'b0) leaked++;
      tick();
    end
    bus.s_valid = 1'b0;
    checks++; if (leaked !== 0 || fwd_cnt - fwd_start !== 20) begin errors++; $display("FAIL early_stop: got leaked %0d forwarded %0d expected 0/20", leaked, fwd_cnt - fwd_start); end
    checks++; if (bus.r_valid !== 1'b1 || bus.r_err !== 1'b1) begin errors++; $display("FAIL early_err: got %0b/%0b expected 1/1", bus.r_valid, bus.r_err); end
    finish_frame(ok);
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL early_frame_cnt: got %0d expected 4", frame_cnt); end
  endtask

  task automatic test_no_valid();
    int sent, bad;
    bit ok;
    fwd_start = fwd_cnt;
    send_pixels(64, 1'b0, sent, bad);
    bus.s_valid = 1'b1;
    #1;
    checks++; if (bus.s_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nov_drain: got s_ready %0b busy %0b expected 0/1", bus.s_ready, busy); end
    bus.s_valid = 1'b0;
    repeat (3) tick();
    bus.pipe_out_done = 1'b1;
    tick();
    bus.pipe_out_done = 1'b0;
    checks++; if (fwd_cnt - fwd_start !== 64) begin errors++; $display("FAIL nov_forwarded: got %0d expected 64", fwd_cnt - fwd_start); end
    checks++; if (bus.r_valid !== 1'b1 || bus.r_err !== 1'b1) begin errors++; $display("FAIL nov_err: got %0b/%0b expected 1/1", bus.r_valid, bus.r_err); end
    finish_frame(ok);
  endtask

  task automatic test_perf();
    int sent, bad;
    bit ok;
    logic [31:0] exp_cyc;
`ifdef CNN_FRAME_PERF_EN
    exp_cyc = 32'd69;
`else
    exp_cyc = 32'd0;
`endif
    fwd_start = fwd_cnt;
    send_pixels(64, 1'b0, sent, bad);
    repeat (4) tick();
    bus.pipe_out_valid = 1'b1;
    bus.pipe_out_done  = 1'b1;
    bus.pipe_out_data  = {32'hE, 32'hF};
    tick();
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_done  = 1'b0;
    checks++; if (frame_cycles !== exp_cyc) begin errors++; $display("FAIL perf_cycles: got %0d expected %0d", frame_cycles, exp_cyc); end
    checks++; if (bus.r_err !== 1'b0 || bus.r_data !== {32'hE, 32'hF}) begin errors++; $display("FAIL perf_result: got %0b/%0h expected 0/e0000000f", bus.r_err, bus.r_data); end
    finish_frame(ok);
    checks++; if (frame_cnt !== 8'd6) begin errors++; $display("FAIL perf_frame_cnt: got %0d expected 6", frame_cnt); end
  endtask

  task automatic test_reset_mid_stream();
    int sent, bad;
    bit ok;
    fwd_start = fwd_cnt;
    send_pixels(30, 1'b0, sent, bad);
    bus.s_valid = 1'b1;
    res_n = 1'b1;
    #1;
    checks++; if (bus.pipe_soft_rst !== 1'b1 || bus.s_ready !== 1'b0 || bus.pipe_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_comb: got soft %0b rdy %0b vld %0b expected 1/0/0", bus.pipe_soft_rst, bus.s_ready, bus.pipe_valid); end
    tick();
    checks++; if (busy !== 1'b0 || frame_cnt !== 8'd0 || bus.r_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got busy %0b cnt %0d rvalid %0b expected 0/0/0", busy, frame_cnt, bus.r_valid); end
    bus.s_valid = 1'b0;
    tick();
    res_n = 1'b0;
    tick();
    fwd_start = fwd_cnt;
    send_pixels(64, 1'b0, sent, bad);
    bus.pipe_out_valid = 1'b1;
    bus.pipe_out_done  = 1'b1;
    bus.pipe_out_data  = {32'h5, 32'h6};
    tick();
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_done  = 1'b0;
    checks++; if (fwd_cnt - fwd_start !== 64 || sent !== 64) begin errors++; $display("FAIL mid_rst_refill: got %0d/%0d expected 64", fwd_cnt - fwd_start, sent); end
    checks++; if (bus.r_valid !== 1'b1 || bus.r_data !== {32'h5, 32'h6} || bus.r_err !== 1'b0) begin errors++; $display("FAIL mid_rst_result: got %0b/%0h/%0b expected 1/500000006/0", bus.r_valid, bus.r_data, bus.r_err); end
    finish_frame(ok);
    checks++; if (frame_cnt !== 8'd1 || data_bad !== 0) begin errors++; $display("FAIL mid_rst_final: got cnt %0d bad %0d expected 1/0", frame_cnt, data_bad); end
  endtask

  initial begin
    res_n              = 1'b1;
    bus.s_valid        = 1'b0;
    bus.s_data         = '0;
    bus.pipe_ready     = 1'b1;
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_data  = '0;
    bus.pipe_out_done  = 1'b0;
    bus.r_ready        = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_simultaneous();
    test_early_done();
    test_no_valid();
    test_perf();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
